// File: rtl/dmem_responder.sv
// dmem_responder: single-port data-memory responder for the CPU load/store port.
// It accepts one request at a time. Each response comes back LATENCY cycles after
// the request is accepted, as a one-cycle resp_valid strobe.
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous reset, active low
//   req_valid  request present            req_ready  high only while idle
//   mem_wen    1 = store, 0 = load        memop      000 B, 001 H, 010 W, 100 BU, 101 HU
//   mem_addr   byte address               memdata    store data, right-aligned
//   rdata      extended load result (0 for stores and errors), held until the next response
//   resp_valid one-cycle response strobe  resp_err   error flag, qualified by resp_valid
//
// Build option
//   DMEM_ALIGN_CHECK_EN  when defined, misaligned halfword and word accesses return
//                        an error. Otherwise they are aligned down and complete normally.
module dmem_responder #(
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_wen,
  input  logic [2:0]  memop,
  input  logic [31:0] mem_addr,
  input  logic [31:0] memdata,
  output logic [31:0] rdata,
  output logic        resp_valid,
  output logic        resp_err
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [3:0]  CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        enter_resp;

  logic        wen_p0;
  logic [2:0]  op_p0;
  logic [31:0] addr_p0, data_p0;

  logic        cur_wen;
  logic [2:0]  cur_op;
  logic [31:0] cur_addr, cur_data;

  logic [31:0] mem [DEPTH];

  logic [31:0] off, word, wdata, ld_val;
  logic [AW-1:0] idx;
  logic [3:0]  be;
  logic        mis, err;

  function automatic logic op_legal(input logic wen, input logic [2:0] op);
    case (op)
      3'b000, 3'b001, 3'b010: return 1'b1;
      3'b100, 3'b101:         return !wen;
      default:                return 1'b0;
    endcase
  endfunction

  // Selects a byte or half from the word and extends it. Halfword and word
  // loads ignore the low address bits, which aligns them down.
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] op,
                                           input logic [1:0] a);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = 8'(w >> {a, 3'b000});
    h = a[1] ? w[31:16] : w[15:0];
    case (op)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return w;
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return 32'd0;
    endcase
  endfunction

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE: if (req_valid) begin
        if (LATENCY == 1) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end else begin
          state_nxt = WAIT;
          cnt_nxt   = CNT_INIT;
        end
      end
      WAIT: if (cnt == 4'd0) begin
        state_nxt  = RESP;
        enter_resp = 1'b1;
      end else begin
        cnt_nxt = cnt - 4'd1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: capture the accepted request
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      wen_p0  <= mem_wen;
      op_p0   <= memop;
      addr_p0 <= mem_addr;
      data_p0 <= memdata;
    end
  end

  // With LATENCY=1 the response is produced on the accepting edge, so the live
  // inputs are used there instead of the captured copy.
  always_comb begin
    cur_wen  = (state == IDLE) ? mem_wen  : wen_p0;
    cur_op   = (state == IDLE) ? memop    : op_p0;
    cur_addr = (state == IDLE) ? mem_addr : addr_p0;
    cur_data = (state == IDLE) ? memdata  : data_p0;
  end

  always_comb begin
    off  = cur_addr - BASE;
    idx  = off[AW+1:2];
    word = mem[idx];
    mis  = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    mis  = (cur_op[1:0] == 2'b01 && cur_addr[0]) || (cur_op == 3'b010 && cur_addr[1:0] != 2'b00);
`else
    mis  = 1'b0;
`endif
    // Any offset bit at or above the array size is out of range. This also
    // catches addresses below BASE, because the subtraction wraps.
    err  = ((off >> (AW + 2)) != 32'd0) || !op_legal(cur_wen, cur_op) || mis;
    case (cur_op[1:0])
      2'b00: begin
        be    = 4'b0001 << cur_addr[1:0];
        wdata = {4{cur_data[7:0]}};
      end
      2'b01: begin
        be    = cur_addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{cur_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = cur_data;
      end
    endcase
    ld_val = load_ext(word, cur_op, cur_addr[1:0]);
  end

  // Stage p1: commit or read on the edge entering RESP. The array is never reset.
  always_ff @(posedge clk) begin
    if (rst && enter_resp && cur_wen && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      rdata    <= 32'd0;
      resp_err <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (enter_resp) begin
        resp_err <= err;
        rdata    <= (err || cur_wen) ? 32'd0 : ld_val;
      end
    end
  end

endmodule
